// File: rtl/fifo_wr_arb_pkg.sv
// Shared types and defaults for the FIFO write-side arbiter.
package fifo_wr_arb_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  localparam int DEF_DATA_WIDTH  = 8;
  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_BURST_LEN   = 4;
  localparam int DEF_STALL_WIDTH = 16;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request strictly after 'last',
// wrapping around, returned both as one-hot and as an index.
module rr_pick #(
  parameter int Num_req   = 4,
  parameter int Idx_width = 2
) (
  input  logic [Num_req-1:0]   req,
  input  logic [Idx_width-1:0] last,
  output logic [Num_req-1:0]   gnt,
  output logic [Idx_width-1:0] idx,
  output logic                 valid
);

  localparam logic [Idx_width:0] NUM = (Idx_width+1)'(Num_req);

  logic [Idx_width-1:0] pos [Num_req];
  logic [Num_req-1:0]   rot_req;

  // rot_req[gi] is the requester sitting gi+1 places after 'last'
  genvar gi;
  generate
    for (gi = 0; gi < Num_req; gi++) begin : g_rot
      logic [Idx_width:0] sum;
      assign sum         = {1'b0, last} + (Idx_width+1)'(gi + 1);
      assign pos[gi]     = (sum >= NUM) ? Idx_width'(sum - NUM) : Idx_width'(sum);
      assign rot_req[gi] = req[pos[gi]];
    end
  endgenerate

  always_comb begin
    valid = |rot_req;
    idx   = '0;
    for (int i = Num_req - 1; i >= 0; i--) begin
      if (rot_req[i]) idx = pos[i];
    end
    gnt = '0;
    if (valid) gnt[idx] = 1'b1;
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter for the async FIFO write port (Wclk domain).
// Define FIFO_WR_ARB_STALL_CNT_EN to add the saturating Stall_cnt output.
module fifo_wr_arbiter
  import fifo_wr_arb_pkg::*;
#(
  parameter int Data_width  = DEF_DATA_WIDTH,
  parameter int Num_req     = DEF_NUM_REQ,
  parameter int Burst_len   = DEF_BURST_LEN
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  ,
  parameter int Stall_width = DEF_STALL_WIDTH
`endif
) (
  input  logic                          Wclk,
  input  logic                          Wrst,
  input  logic [Num_req-1:0]            Req,
  input  logic [Num_req*Data_width-1:0] Req_data,
  input  logic                          Wfull,
  output logic                          Winc,
  output logic [Data_width-1:0]         Wdata,
  output logic [Num_req-1:0]            Ack,
  output logic [Num_req-1:0]            Gnt,
  output logic                          Busy
`ifdef FIFO_WR_ARB_STALL_CNT_EN
  ,
  output logic [Stall_width-1:0]        Stall_cnt
`endif
);

  localparam int IW = idx_width(Num_req);
  localparam int BW = $clog2(Burst_len) + 1;
  localparam logic [BW-1:0] BCNT_LAST = BW'(Burst_len - 1);

  arb_state_t        state_reg, state_next;
  logic [Num_req-1:0] gnt_reg, gnt_next;
  logic              busy_reg, busy_next;
  logic [BW-1:0]     bcnt_reg, bcnt_next;
  logic [IW-1:0]     owner_reg, owner_next;
  logic [IW-1:0]     last_reg, last_next;

  logic [Num_req-1:0] pick_gnt;
  logic [IW-1:0]      pick_idx;
  logic               pick_valid;
  logic               in_grant;
  logic               owner_req;

  rr_pick #(
    .Num_req  (Num_req),
    .Idx_width(IW)
  ) u_rr_pick (
    .req  (Req),
    .last (last_reg),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .valid(pick_valid)
  );

  assign in_grant  = (state_reg == GRANT);
  assign owner_req = Req[owner_reg];

  // Write strobe is a same-cycle function of Wfull so the FIFO sees it on this edge
  always_comb begin
    Winc  = in_grant & owner_req & ~Wfull;
    Wdata = '0;
    if (in_grant) Wdata = Req_data[owner_reg*Data_width +: Data_width];
    Ack   = gnt_reg & {Num_req{Winc}};
  end

  assign Gnt  = gnt_reg;
  assign Busy = busy_reg;

  always_comb begin
    state_next = state_reg;
    gnt_next   = gnt_reg;
    busy_next  = busy_reg;
    bcnt_next  = bcnt_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    case (state_reg)
      IDLE: begin
        if (pick_valid) begin
          state_next = GRANT;
          gnt_next   = pick_gnt;
          owner_next = pick_idx;
          bcnt_next  = '0;
          busy_next  = 1'b1;
        end
      end
      GRANT: begin
        if (Winc) bcnt_next = bcnt_reg + 1'b1;
        // Owner withdrawal and burst exhaustion share one exit path
        if (!owner_req || (Winc && (bcnt_reg == BCNT_LAST))) begin
          state_next = IDLE;
          last_next  = owner_reg;
          gnt_next   = '0;
          busy_next  = 1'b0;
          bcnt_next  = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge Wclk or negedge Wrst) begin
    if (!Wrst) begin
      state_reg <= IDLE;
      gnt_reg   <= '0;
      busy_reg  <= 1'b0;
      bcnt_reg  <= '0;
      owner_reg <= '0;
      last_reg  <= IW'(Num_req - 1);
    end else begin
      state_reg <= state_next;
      gnt_reg   <= gnt_next;
      busy_reg  <= busy_next;
      bcnt_reg  <= bcnt_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
    end
  end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
  logic [Stall_width-1:0] stall_reg;

  always_ff @(posedge Wclk or negedge Wrst) begin
    if (!Wrst) begin
      stall_reg <= '0;
    end else if (in_grant && owner_req && Wfull && !(&stall_reg)) begin
      stall_reg <= stall_reg + 1'b1;
    end
  end

  assign Stall_cnt = stall_reg;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter for the asynchronous FIFO. It shares the single FIFO write port (increment/data, honouring the full flag) among Num_req requesters in the write clock domain, using round-robin selection with bounded per-grant bursts. It sits directly in front of the FIFO write-pointer/full logic and memory write port; all logic runs on Wclk.

## Interface
- Data_width, 8: width of one FIFO word
- Num_req, 4: number of requesters (2..8)
- Burst_len, 4: maximum writes per grant (1..16)
- Stall_width, 16: stall counter width (only with FIFO_WR_ARB_STALL_CNT_EN)
- Wclk  in  1  write-domain clock, rising edge
- Wrst  in  1  asynchronous active-low reset
- Req  in  Num_req  per-requester write request (level); held with data until acked
- Req_data  in  Num_req*Data_width  packed data; requester i at [i*Data_width +: Data_width]
- Wfull  in  1  FIFO full flag (write domain)
- Winc  out  1  FIFO write increment, combinational
- Wdata  out  Data_width  FIFO write data, combinational mux of owner's data
- Ack  out  Num_req  one-hot; Ack[i]=1 means requester i's word is written this edge
- Gnt  out  Num_req  registered one-hot current owner; 0 when idle
- Busy  out  1  registered; 1 while in GRANT
- Stall_cnt  out  Stall_width  saturating stall cycles (macro only)

## Operation
- FSM states IDLE, GRANT; reset state IDLE.
- IDLE: if |Req, pick owner = first set Req scanning from (Last+1) mod Num_req upward with wrap-around; load Gnt, clear burst count Bcnt, go to GRANT. Otherwise stay.
- GRANT: Winc = Req[owner] & ~Wfull; Wdata = Req_data[owner]; Ack = Gnt & {Num_req{Winc}}.
- Each Winc increments Bcnt (width clog2(Burst_len)+1).
- Leave GRANT to IDLE when Req[owner]==0, or when Winc and Bcnt==Burst_len-1. On leaving: Last <= owner, Gnt <= 0, Busy <= 0.
- Wfull high in GRANT: Winc=0, no Ack, Bcnt holds, grant held (no pre-emption).
- Requests from non-owners are ignored until re-arbitration; a requester may drop Req at any time (no data lost, since only acked words are written).
- IDLE: Winc=0, Ack=0, Wdata=0.
- Reset values: state IDLE, Gnt 0, Busy 0, Bcnt 0, Last Num_req-1 (requester 0 wins first), Stall_cnt 0; combinational outputs therefore 0.
- Reset asserted mid-burst: immediate return to above values; a word in flight is not written.

## Timing
- Arbitration latency: Req rising in IDLE -> Gnt/Busy high next edge -> first Winc possible in that cycle (1-cycle bubble).
- Throughput: Burst_len words per Burst_len+1 cycles with continuous requests and no full.
- Winc/Ack are same-cycle functions of Wfull; the FIFO samples them at the same Wclk edge.
- Wfull rising in the same cycle as the last burst word: no write, Bcnt unchanged, burst finishes after Wfull falls.
- Req[owner] falling in the same cycle as Bcnt reaching the limit: single exit to IDLE.

## Configuration
- FIFO_WR_ARB_STALL_CNT_EN defined: Stall_cnt port present; increments each cycle in GRANT with Req[owner]&Wfull, saturates at all-ones, cleared only by reset.
- Not defined: Stall_cnt port and counter absent; arbitration behaviour identical.

## Structure
- Package fifo_wr_arb_pkg: FSM state encoding (IDLE=0, GRANT=1), state typedef, default parameter constants.
- Sub-module rr_pick: combinational round-robin picker (Req vector, Last index -> one-hot grant, valid).

## Test plan
- Single requester: Req=0001, Req_data[0] sequence 0x11..0x16, Wfull=0 -> Gnt=0001 one cycle later; 4 writes 0x11..0x14, 1 idle cycle, then 0x15,0x16.
- Round-robin: Req=1111 continuously -> owner order 0,1,2,3,0; each gets 4 consecutive Acks; Busy low exactly one cycle between grants.
- Full stall: owner 2 mid-burst at Bcnt=2, Wfull high 5 cycles -> Winc=0, Ack=0, Gnt held at 0100; after Wfull low exactly 2 more writes; Stall_cnt=5 with macro.
- Early drop: owner 1 drops Req after 1 write -> IDLE next edge; next grant goes to requester 2 if requesting, else 3,0,1.
- Reset mid-burst: Wrst low during Winc=1 -> all outputs 0 immediately; after release, Req=1010 grants requester 1 first.
- Saturation (macro, Stall_width=4): Wfull held 20 cycles in GRANT -> Stall_cnt stops at 15.
